// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the CalcuTEC datapath: fetch/decode/execute/memory/writeback
// control, architectural flags, condition evaluation and an iterated shift-add multiply.
module multicycle_ctrl #(
  parameter int MUL_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] ALU_flags,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       sel_addr,
  output logic       IR_wr,
  output logic       PC_wr,
  output logic       pc_src,
  output logic       sel_B,
  output logic       mul_start,
  output logic       mul_step,
  output logic       reg_wr,
  output logic       sel_WB,
  output logic [3:0] flags,
  output logic       illegal,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, EXEC, MUL, MEMADR, MEM, BRANCH, WB
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] mul_cnt;
  logic             mul_last;
  logic             cond_ok;

  // flags bit order: 0 Z, 1 N, 2 C, 3 V
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic z, n, cy, v;
    z  = f[0];
    n  = f[1];
    cy = f[2];
    v  = f[3];
    case (c)
      4'd0:    cond_pass = z;
      4'd1:    cond_pass = ~z;
      4'd2:    cond_pass = cy;
      4'd3:    cond_pass = ~cy;
      4'd4:    cond_pass = n;
      4'd5:    cond_pass = ~n;
      4'd6:    cond_pass = v;
      4'd7:    cond_pass = ~v;
      4'd8:    cond_pass = ~z & cy;
      4'd9:    cond_pass = z | ~cy;
      4'd10:   cond_pass = (n == v);
      4'd11:   cond_pass = (n != v);
      4'd12:   cond_pass = ~z & (n == v);
      4'd13:   cond_pass = z | (n != v);
      default: cond_pass = 1'b1;
    endcase
  endfunction

  assign mul_last = (mul_cnt == CNT_W'(MUL_CYCLES - 1));
  assign cond_ok  = cond_pass(cond, flags);

  always_comb begin
    next_state = state;
    illegal    = 1'b0;
    case (state)
      IDLE:   next_state = FETCH;
      FETCH:  if (mem_ready) next_state = DECODE;
      DECODE: begin
        if (!cond_ok)
          next_state = FETCH;
        else if (op == 2'd0)
          next_state = (funct[5:1] == 5'd0) ? MUL : EXEC;
        else if (op == 2'd1 && funct[2])
          next_state = MEMADR;
        else if (op == 2'd2)
          next_state = BRANCH;
        else begin
          illegal    = 1'b1;
          next_state = FETCH;
        end
      end
      EXEC:   next_state = WB;
      MUL:    if (mul_last) next_state = WB;
      MEMADR: next_state = MEM;
      MEM:    if (mem_ready) next_state = funct[0] ? WB : FETCH;
      BRANCH: next_state = FETCH;
      WB:     next_state = FETCH;
      default: next_state = IDLE;
    endcase
  end

  // Instruction fetch completes in the same cycle memory answers.
  assign IR_wr = (state == FETCH) & mem_ready;
  assign PC_wr = IR_wr | pc_src;

  // Moore outputs are registered from the state being entered, so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      flags     <= 4'd0;
      mul_cnt   <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      sel_addr  <= 1'b0;
      pc_src    <= 1'b0;
      sel_B     <= 1'b0;
      mul_start <= 1'b0;
      mul_step  <= 1'b0;
      reg_wr    <= 1'b0;
      sel_WB    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= next_state;

      if (funct[0] && (state == EXEC || (state == MUL && mul_last)))
        flags <= ALU_flags;

      if (state == MUL)
        mul_cnt <= mul_last ? '0 : mul_cnt + 1'b1;

      mem_rd    <= (next_state == FETCH) | ((next_state == MEM) & funct[0]);
      mem_wr    <= (next_state == MEM) & ~funct[0];
      sel_addr  <= (next_state == MEM);
      pc_src    <= (next_state == BRANCH);
      sel_B     <= ((next_state == EXEC) & funct[5]) | (next_state == MEMADR);
      mul_start <= (next_state == MUL) & (state != MUL);
      mul_step  <= (next_state == MUL);
      reg_wr    <= (next_state == WB);
      sel_WB    <= (next_state == WB) & (state == MEM);
      busy      <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios plus randomized instructions
// compared per-instruction against an outcome-level reference model.
module tb_multicycle_ctrl;

  localparam int MUL_CYCLES = 32;
  localparam int CNT_W      = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] cond = 4'd0;
  logic [1:0] op = 2'd0;
  logic [5:0] funct = 6'd0;
  logic [3:0] ALU_flags = 4'd0;
  logic       mem_ready = 1'b0;
  logic       mem_rd, mem_wr, sel_addr, IR_wr, PC_wr, pc_src, sel_B;
  logic       mul_start, mul_step, reg_wr, sel_WB, illegal, busy;
  logic [3:0] flags;

  int tests_run = 0;
  int failures  = 0;
  logic [3:0] model_flags = 4'd0;

  multicycle_ctrl #(.MUL_CYCLES(MUL_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .cond(cond), .op(op), .funct(funct),
    .ALU_flags(ALU_flags), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .sel_addr(sel_addr), .IR_wr(IR_wr), .PC_wr(PC_wr), .pc_src(pc_src), .sel_B(sel_B),
    .mul_start(mul_start), .mul_step(mul_step), .reg_wr(reg_wr), .sel_WB(sel_WB),
    .flags(flags), .illegal(illegal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Odd codes invert the even code below them; codes 14/15 always hold.
  function automatic bit condHolds(input logic [3:0] c, input logic [3:0] f);
    bit z, n, cy, v, base;
    z = f[0]; n = f[1]; cy = f[2]; v = f[3];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return base ^ c[0];
  endfunction

  function automatic logic [12:0] allOutputs();
    return {mem_rd, mem_wr, sel_addr, IR_wr, PC_wr, pc_src, sel_B,
            mul_start, mul_step, reg_wr, sel_WB, illegal, busy};
  endfunction

  // Leaves the bench at a falling edge with the DUT in its first FETCH cycle.
  task automatic resetDut();
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("reset_outputs", 32'(allOutputs()), 32'd0);
    checkOutput("reset_flags", 32'(flags), 32'd0);
    model_flags = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_outputs", 32'(allOutputs()), 32'd0);
    @(negedge clk);
    checkOutput("fetch_after_idle", 32'({busy, mem_rd, sel_addr}), 32'b110);
  endtask

  // Runs one instruction from its first FETCH cycle up to the next FETCH, acting as the
  // memory (fw/mw wait cycles), then compares per-instruction tallies with the model.
  task automatic applyStimulus(input string name, input logic [3:0] c, input logic [1:0] o,
                               input logic [5:0] f, input logic [3:0] af,
                               input int fw, input int mw, input int abort_at);
    bit pass, is_dp, is_mul, is_ldr, is_str, is_br, is_ill, seen_ir, done;
    int cyc, wait_cnt, target, extra;
    int n_ir, n_pcwr, n_br, n_reg, n_wb, n_fetch_rd, n_data_rd, n_data_wr;
    int n_selb, n_mstart, n_mstep, n_ill, n_overlap, n_idle;
    cond = c; op = o; funct = f; ALU_flags = af;
    pass   = condHolds(c, model_flags);
    is_mul = pass && o == 2'd0 && f[5:1] == 5'd0;
    is_dp  = pass && o == 2'd0 && !is_mul;
    is_ldr = pass && o == 2'd1 && f[2] && f[0];
    is_str = pass && o == 2'd1 && f[2] && !f[0];
    is_br  = pass && o == 2'd2;
    is_ill = pass && (o == 2'd3 || (o == 2'd1 && !f[2]));
    {n_ir, n_pcwr, n_br, n_reg, n_wb, n_fetch_rd, n_data_rd, n_data_wr} = '0;
    {n_selb, n_mstart, n_mstep, n_ill, n_overlap, n_idle} = '0;
    seen_ir = 0; done = 0; cyc = 0; wait_cnt = 0;
    while (!done && cyc < 400) begin
      if (seen_ir && mem_rd && !sel_addr) begin
        done = 1;
      end else if (abort_at > 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        #1;
        checkOutput({name, "_abort_outputs"}, 32'(allOutputs()), 32'd0);
        checkOutput({name, "_abort_flags"}, 32'(flags), 32'd0);
        checkOutput({name, "_abort_steps"}, 32'(n_mstep), 32'(abort_at - 2));
        model_flags = 4'd0;
        return;
      end else begin
        if (mem_rd || mem_wr) begin
          target = sel_addr ? mw : fw;
          mem_ready = (wait_cnt >= target);
          wait_cnt = mem_ready ? 0 : wait_cnt + 1;
        end else begin
          mem_ready = 1'($urandom_range(0, 1));
        end
        #1;
        if (IR_wr) seen_ir = 1;
        n_ir       += int'(IR_wr);
        n_pcwr     += int'(PC_wr);
        n_br       += int'(PC_wr && pc_src);
        n_reg      += int'(reg_wr);
        n_wb       += int'(sel_WB);
        n_fetch_rd += int'(mem_rd && !sel_addr);
        n_data_rd  += int'(mem_rd && sel_addr);
        n_data_wr  += int'(mem_wr && sel_addr);
        n_selb     += int'(sel_B);
        n_mstart   += int'(mul_start);
        n_mstep    += int'(mul_step);
        n_ill      += int'(illegal);
        n_overlap  += int'((mem_rd && mem_wr) || (reg_wr && PC_wr));
        n_idle     += int'(!busy);
        cyc++;
        @(negedge clk);
      end
    end
    checkOutput({name, "_terminated"}, 32'(done), 32'd1);
    if (is_dp)       extra = 2;
    else if (is_mul) extra = MUL_CYCLES + 1;
    else if (is_ldr) extra = mw + 3;
    else if (is_str) extra = mw + 2;
    else if (is_br)  extra = 1;
    else             extra = 0;
    if ((is_dp || is_mul) && f[0]) model_flags = af;
    checkOutput({name, "_cycles"}, 32'(cyc), 32'(fw + 2 + extra));
    checkOutput({name, "_ir_wr"}, 32'(n_ir), 32'd1);
    checkOutput({name, "_pc_wr"}, 32'(n_pcwr), 32'(1 + int'(is_br)));
    checkOutput({name, "_branch"}, 32'(n_br), 32'(is_br));
    checkOutput({name, "_reg_wr"}, 32'(n_reg), 32'(is_dp || is_mul || is_ldr));
    checkOutput({name, "_sel_wb"}, 32'(n_wb), 32'(is_ldr));
    checkOutput({name, "_fetch_rd"}, 32'(n_fetch_rd), 32'(fw + 1));
    checkOutput({name, "_data_rd"}, 32'(n_data_rd), 32'(is_ldr ? mw + 1 : 0));
    checkOutput({name, "_data_wr"}, 32'(n_data_wr), 32'(is_str ? mw + 1 : 0));
    checkOutput({name, "_sel_b"}, 32'(n_selb), 32'(int'(is_dp && f[5]) + int'(is_ldr || is_str)));
    checkOutput({name, "_mul_start"}, 32'(n_mstart), 32'(is_mul));
    checkOutput({name, "_mul_step"}, 32'(n_mstep), 32'(is_mul ? MUL_CYCLES : 0));
    checkOutput({name, "_illegal"}, 32'(n_ill), 32'(is_ill));
    checkOutput({name, "_overlap"}, 32'(n_overlap), 32'd0);
    checkOutput({name, "_busy"}, 32'(n_idle), 32'd0);
    checkOutput({name, "_flags"}, 32'(flags), 32'(model_flags));
  endtask

  initial begin
    logic [1:0] r_op;
    logic [5:0] r_funct;
    logic [3:0] r_cond;
    resetDut();
    applyStimulus("adds", 4'd14, 2'd0, 6'b101001, 4'b0001, 0, 0, 0);
    applyStimulus("bne",  4'd1,  2'd2, 6'b000000, 4'b0000, 0, 0, 0);
    applyStimulus("beq",  4'd0,  2'd2, 6'b000000, 4'b0000, 0, 0, 0);
    applyStimulus("ldr",  4'd14, 2'd1, 6'b000101, 4'b0000, 3, 2, 0);
    applyStimulus("str",  4'd14, 2'd1, 6'b000100, 4'b0000, 1, 1, 0);
    applyStimulus("muls", 4'd14, 2'd0, 6'b000001, 4'b0010, 0, 0, 0);
    applyStimulus("ill",  4'd15, 2'd3, 6'b000000, 4'b0000, 0, 0, 0);
    applyStimulus("ill_mem", 4'd14, 2'd1, 6'b000001, 4'b0000, 0, 0, 0);
    applyStimulus("mul_abort", 4'd14, 2'd0, 6'b000001, 4'b1111, 0, 0, 11);
    resetDut();
    for (int i = 0; i < 60; i++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_funct = 6'($urandom);
      r_cond  = ($urandom_range(0, 3) == 0) ? 4'd14 : 4'($urandom);
      if (r_op == 2'd0 && $urandom_range(0, 3) == 0) r_funct[5:1] = 5'd0;
      if (r_op == 2'd1 && $urandom_range(0, 3) != 0) r_funct[2] = 1'b1;
      applyStimulus($sformatf("rnd%0d", i), r_cond, r_op, r_funct, 4'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
